tse_sync_filter: RTL and testbench



---
 rtl/tse_sync_filter.sv | 71 +++++++
 tb/tb_tse_sync_filter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tse_sync_filter.sv
// tse_sync_filter: multi-channel single-bit synchroniser with optional stability filter
// and per-channel rise/fall pulses for quasi-static status/control bits.
module tse_sync_filter #(
    parameter int N_CH = 16,
    parameter int STAGES = 2,
    parameter int FILTER_CYCLES = 0,
    parameter logic [N_CH-1:0] RST_VAL = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] async_i,
    output logic [N_CH-1:0] sync_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            change_o
);
    logic [N_CH-1:0] chain [STAGES];
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) chain[k] <= RST_VAL;
        end else begin
            chain[0] <= async_i;
            for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
        end
    end

    assign s = chain[STAGES-1];

    generate
        if (FILTER_CYCLES > 0) begin : g_filt
            localparam int CW = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);
            logic [N_CH-1:0] filt;
            logic [CW-1:0] cnt [N_CH];
            // a differing value must persist FILTER_CYCLES edges; any return to filt restarts the count
            always_ff @(posedge clk) begin
                if (reset) begin
                    filt <= RST_VAL;
                    for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (s[i] == filt[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CMAX) begin
                            filt[i] <= s[i];
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end
            assign sync_o = filt;
        end else begin : g_nofilt
            assign sync_o = s;
        end
    endgenerate

    // prev resets alongside sync_o so reset itself never produces an edge pulse
    always_ff @(posedge clk) begin
        if (reset) prev <= RST_VAL;
        else prev <= sync_o;
    end

    assign rise_o = sync_o & ~prev;
    assign fall_o = ~sync_o & prev;
    assign change_o = |(rise_o | fall_o);
endmodule

// File: tb/tb_tse_sync_filter.sv
// tb_tse_sync_filter: timed-expectation scoreboard across four configurations
// (F=0/S=2, F=0/S=4, F=4/S=2, F=2/S=2) sharing one stimulus stream.
module tb_tse_sync_filter;
    localparam int SY = 0, RI = 1, FA = 2, CH = 3;
    localparam logic [15:0] RV = 16'h00F0;

    typedef struct {
        int cyc;
        int dut;
        int sel;
        logic [15:0] mask;
        logic [15:0] exp;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] async_i;
    logic [15:0] sync [4];
    logic [15:0] rise [4];
    logic [15:0] fall [4];
    logic chg [4];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tse_sync_filter #(.N_CH(16), .STAGES(2), .FILTER_CYCLES(0), .RST_VAL(RV)) d0 (
        .clk(clk), .reset(reset), .async_i(async_i),
        .sync_o(sync[0]), .rise_o(rise[0]), .fall_o(fall[0]), .change_o(chg[0]));
    tse_sync_filter #(.N_CH(16), .STAGES(4), .FILTER_CYCLES(0), .RST_VAL(RV)) d1 (
        .clk(clk), .reset(reset), .async_i(async_i),
        .sync_o(sync[1]), .rise_o(rise[1]), .fall_o(fall[1]), .change_o(chg[1]));
    tse_sync_filter #(.N_CH(16), .STAGES(2), .FILTER_CYCLES(4), .RST_VAL(RV)) d2 (
        .clk(clk), .reset(reset), .async_i(async_i),
        .sync_o(sync[2]), .rise_o(rise[2]), .fall_o(fall[2]), .change_o(chg[2]));
    tse_sync_filter #(.N_CH(16), .STAGES(2), .FILTER_CYCLES(2), .RST_VAL(RV)) d3 (
        .clk(clk), .reset(reset), .async_i(async_i),
        .sync_o(sync[3]), .rise_o(rise[3]), .fall_o(fall[3]), .change_o(chg[3]));

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] sig_val(input int d, input int s);
        return s == SY ? sync[d] : s == RI ? rise[d] : s == FA ? fall[d] : {15'b0, chg[d]};
    endfunction

    task automatic expect_at(input int c, input int d, input int s, input logic [15:0] m,
                             input logic [15:0] e, input string t);
        exp_t x;
        x.cyc = c;
        x.dut = d;
        x.sel = s;
        x.mask = m;
        x.exp = e;
        x.tag = $sformatf("%s_d%0d", t, d);
        sb.push_back(x);
    endtask

    task automatic pulse(input int c, input int d, input int s, input logic [15:0] m,
                         input logic [15:0] e, input string t);
        expect_at(c - 1, d, s, m, 16'h0, {t, "_pre"});
        expect_at(c, d, s, m, e, t);
        expect_at(c + 1, d, s, m, 16'h0, {t, "_post"});
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, sig_val(sb[i].dut, sb[i].sel) & sb[i].mask, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        async_i = 16'hFFFF;
        for (int c = 1; c <= 4; c++)
            for (int d = 0; d < 4; d++) begin
                expect_at(c, d, SY, 16'hFFFF, RV, "rst_sync");
                expect_at(c, d, RI, 16'hFFFF, 16'h0, "rst_rise");
                expect_at(c, d, FA, 16'hFFFF, 16'h0, "rst_fall");
                expect_at(c, d, CH, 16'h1, 16'h0, "rst_chg");
            end
        tick(3);
        reset = 1'b0;
        async_i = 16'h0;
        tick(12);

        n = cyc;
        async_i = 16'h0008;
        expect_at(n + 1, 0, SY, 16'h8, 16'h0, "lat_s2_early");
        expect_at(n + 2, 0, SY, 16'h8, 16'h8, "lat_s2");
        pulse(n + 2, 0, RI, 16'h8, 16'h8, "lat_s2_rise");
        pulse(n + 2, 0, CH, 16'h1, 16'h1, "lat_s2_chg");
        expect_at(n + 3, 1, SY, 16'h8, 16'h0, "lat_s4_early");
        expect_at(n + 4, 1, SY, 16'h8, 16'h8, "lat_s4");
        pulse(n + 4, 1, RI, 16'h8, 16'h8, "lat_s4_rise");
        pulse(n + 4, 1, CH, 16'h1, 16'h1, "lat_s4_chg");
        expect_at(n + 5, 2, SY, 16'h8, 16'h0, "lat_f4_early");
        expect_at(n + 6, 2, SY, 16'h8, 16'h8, "lat_f4");
        tick(12);
        async_i = 16'h0;
        tick(12);

        n = cyc;
        async_i = 16'h0001;
        for (int c = n + 1; c <= n + 10; c++) begin
            expect_at(c, 2, SY, 16'h1, 16'h0, "glitch3_sync");
            expect_at(c, 2, RI, 16'h1, 16'h0, "glitch3_rise");
            expect_at(c, 2, FA, 16'h1, 16'h0, "glitch3_fall");
        end
        tick(3);
        async_i = 16'h0;
        tick(10);

        n = cyc;
        async_i = 16'h0001;
        expect_at(n + 5, 2, SY, 16'h1, 16'h0, "pulse6_early");
        expect_at(n + 6, 2, SY, 16'h1, 16'h1, "pulse6_up");
        pulse(n + 6, 2, RI, 16'h1, 16'h1, "pulse6_rise");
        tick(6);
        async_i = 16'h0;
        expect_at(n + 11, 2, SY, 16'h1, 16'h1, "pulse6_hold");
        expect_at(n + 12, 2, SY, 16'h1, 16'h0, "pulse6_down");
        pulse(n + 12, 2, FA, 16'h1, 16'h1, "pulse6_fall");
        tick(12);

        n = cyc;
        for (int c = n + 1; c <= n + 55; c++) begin
            expect_at(c, 3, SY, 16'h0080, 16'h0, "alt_sync");
            expect_at(c, 3, RI, 16'h0080, 16'h0, "alt_rise");
            expect_at(c, 3, FA, 16'h0080, 16'h0, "alt_fall");
        end
        for (int i = 0; i < 50; i++) begin
            async_i[7] = ~async_i[7];
            tick(1);
        end
        tick(10);

        n = cyc;
        async_i = 16'hA5A5;
        pulse(n + 2, 0, RI, 16'hFFFF, 16'hA5A5, "multi_rise");
        pulse(n + 2, 0, CH, 16'h1, 16'h1, "multi_chg");
        tick(6);
        n = cyc;
        async_i = 16'h5A5A;
        pulse(n + 2, 0, RI, 16'hFFFF, 16'h5A5A, "swap_rise");
        pulse(n + 2, 0, FA, 16'hFFFF, 16'hA5A5, "swap_fall");
        pulse(n + 2, 0, CH, 16'h1, 16'h1, "swap_chg");
        tick(6);
        async_i = 16'h0;
        tick(12);

        n = cyc;
        async_i = 16'h0002;
        for (int c = n + 1; c <= n + 10; c++) expect_at(c, 2, SY, 16'h2, 16'h0, "midrst_sync");
        for (int c = n + 5; c <= n + 10; c++) expect_at(c, 2, RI, 16'h2, 16'h0, "midrst_rise");
        expect_at(n + 11, 2, SY, 16'h2, 16'h2, "midrst_up");
        expect_at(n + 11, 2, RI, 16'h2, 16'h2, "midrst_rise_up");
        for (int c = n + 5; c <= n + 6; c++) begin
            expect_at(c, 2, SY, 16'hFFFF, RV, "midrst_val");
            expect_at(c, 2, RI, 16'hFFFF, 16'h0, "midrst_norise");
            expect_at(c, 2, FA, 16'hFFFF, 16'h0, "midrst_nofall");
            expect_at(c, 2, CH, 16'h1, 16'h0, "midrst_nochg");
            expect_at(c, 0, SY, 16'hFFFF, RV, "midrst_val");
            expect_at(c, 0, CH, 16'h1, 16'h0, "midrst_nochg");
        end
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(20);

        check("unchecked_entries", 16'(sb.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
